// File: rtl/rf_pkg.sv
// Shared defaults and flat-vector slicing helper for the bypassing register file.
package rf_pkg;

    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;
    localparam int NRD_MAX  = 4;

    localparam int SLICE_W  = 64;
    localparam int FLAT_W   = NRD_MAX * SLICE_W;

    // Returns field idx of width w from a flat vector, zero-extended to SLICE_W.
    function automatic logic [SLICE_W-1:0] get_slice(input logic [FLAT_W-1:0] flat,
                                                     input int unsigned idx,
                                                     input int unsigned w);
        logic [FLAT_W-1:0]  sh;
        logic [SLICE_W-1:0] res;
        sh  = flat >> (idx * w);
        res = '0;
        for (int unsigned b = 0; b < SLICE_W; b++) begin
            if (b < w) res[b] = sh[b];
        end
        return res;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits with flush > issue > writeback priority and
// a read-port lookup that masks registers being written back this cycle.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int NRD  = 2,
    parameter int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD-1:0]  rd_busy,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    input  logic            flush
);

    logic [NREG-1:0] busy;

    logic iss_valid;
    logic wb_valid;

    assign iss_valid = iss_en && (iss_addr != '0);
    // A writeback to the register being re-issued leaves the new producer's bit set.
    assign wb_valid  = wr_en && (wr_addr != '0) && !(iss_en && (iss_addr == wr_addr));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            if (wb_valid)  busy[wr_addr]  <= 1'b0;
            if (iss_valid) busy[iss_addr] <= 1'b1;
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_port
        logic [AW-1:0] addr;
        assign addr        = AW'(get_slice(FLAT_W'(rd_addr), gi, AW));
        assign rd_busy[gi] = busy[addr] && !(wr_en && (wr_addr == addr));
    end

endmodule

// File: rtl/regfile_bypass_sb.sv
// Multi-port register file with write-through bypass; the busy-bit scoreboard
// is built only when REGFILE_SCOREBOARD_EN is defined, otherwise rd_busy is 0.
module regfile_bypass_sb
    import rf_pkg::*;
#(
    parameter  int XLEN = XLEN_DEF,
    parameter  int NREG = NREG_DEF,
    parameter  int NRD  = 2,
    localparam int AW   = $clog2(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush
);

    logic [XLEN-1:0] regs [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (wr_en && (wr_addr != '0)) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;

        assign addr = AW'(get_slice(FLAT_W'(rd_addr), gi, AW));

        always_comb begin
            if (addr == '0)
                data = '0;
            else if (wr_en && (wr_addr == addr))
                data = wr_data;
            else
                data = regs[addr];
        end

        assign rd_data[gi*XLEN +: XLEN] = data;
    end

`ifdef REGFILE_SCOREBOARD_EN
    rf_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .AW   (AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush)
    );
`else
    logic unused_sb_inputs;
    assign unused_sb_inputs = ^{iss_en, iss_addr, flush};
    assign rd_busy = '0;
`endif

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Scoreboard-style bench: stimulus queues expected port values per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_regfile_bypass_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

`ifdef REGFILE_SCOREBOARD_EN
    localparam bit SB = 1'b1;
`else
    localparam bit SB = 1'b0;
`endif

    logic                clk;
    logic                rst;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;

    regfile_bypass_sb #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush)
    );

    typedef struct {
        int          cyc;
        int          port;
        logic [31:0] data;
        logic        busy;
        string       tag;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] ad;
            logic        ab;
            e  = q.pop_front();
            ad = rd_data[e.port*XLEN +: XLEN];
            ab = rd_busy[e.port];
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s p%0d: check missed its cycle (due %0d, now %0d)", e.tag, e.port, e.cyc, cyc);
            end else if (ad !== e.data || ab !== e.busy) begin
                errors++;
                $display("FAIL %s p%0d: got data=%h busy=%b, expected data=%h busy=%b",
                         e.tag, e.port, ad, ab, e.data, e.busy);
            end
        end
    end

    task automatic step(input string tag, input bit r,
                        input bit we, input int wa, input logic [31:0] wd,
                        input bit ie, input int ia, input bit fl,
                        input int a0, input int a1,
                        input logic [31:0] e0, input logic b0,
                        input logic [31:0] e1, input logic b1);
        exp_t x;
        @(posedge clk);
        #1;
        rst      = r;
        wr_en    = we;
        wr_addr  = AW'(wa);
        wr_data  = wd;
        iss_en   = ie;
        iss_addr = AW'(ia);
        flush    = fl;
        rd_addr  = {AW'(a1), AW'(a0)};
        x.cyc = cyc; x.tag = tag;
        x.port = 0; x.data = e0; x.busy = b0; q.push_back(x);
        x.port = 1; x.data = e1; x.busy = b1; q.push_back(x);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0; rd_addr = '0;
        repeat (2) @(posedge clk);

        for (int a = 0; a < NREG; a++)
            step("reset_read", 1, 0,0,0, 0,0,0, a, NREG-1-a, 0,0, 0,0);

        step("wr_x5",       0, 1,5,32'hDEADBEEF, 0,0,0, 3,7, 0,0, 0,0);
        step("rdback_x5",   0, 1,0,32'h00001234, 0,0,0, 5,5, 32'hDEADBEEF,0, 32'hDEADBEEF,0);
        step("x0_is_zero",  0, 0,0,0, 0,0,0, 0,5, 0,0, 32'hDEADBEEF,0);
        step("bypass_x7",   0, 1,7,32'hA5A5A5A5, 0,0,0, 3,7, 0,0, 32'hA5A5A5A5,0);
        step("array_x7",    0, 0,0,0, 0,0,0, 7,3, 32'hA5A5A5A5,0, 0,0);
        step("wr_x31",      0, 1,31,32'hFFFFFFFF, 0,0,0, 0,0, 0,0, 0,0);
        step("rd_x31",      0, 0,0,0, 0,0,0, 31,31, 32'hFFFFFFFF,0, 32'hFFFFFFFF,0);

        step("iss_x9",      0, 0,0,0, 1,9,0, 9,9, 0,0, 0,0);
        step("busy_x9",     0, 0,0,0, 0,0,0, 9,5, 0,SB, 32'hDEADBEEF,0);
        step("wb_x9",       0, 1,9,32'h55, 0,0,0, 9,9, 32'h55,0, 32'h55,0);
        step("clr_x9",      0, 0,0,0, 0,0,0, 9,0, 32'h55,0, 0,0);
        step("iss_wb_x9",   0, 1,9,32'h66, 1,9,0, 9,9, 32'h66,0, 32'h66,0);
        step("still_busy9", 0, 0,0,0, 0,0,0, 9,9, 32'h66,SB, 32'h66,SB);
        step("iss4_flush",  0, 0,0,0, 1,4,1, 4,9, 0,0, 32'h66,SB);
        step("after_flush", 0, 0,0,0, 0,0,0, 4,9, 0,0, 32'h66,0);
        step("iss_x0",      0, 0,0,0, 1,0,0, 0,0, 0,0, 0,0);
        step("x0_not_busy", 0, 0,0,0, 0,0,0, 0,0, 0,0, 0,0);
        step("wb_nonbusy",  0, 1,12,32'h12, 0,0,0, 12,9, 32'h12,0, 32'h66,0);

        step("wr_x10",      0, 1,10,32'hAA, 0,0,0, 12,0, 32'h12,0, 0,0);
        step("wr_x11",      0, 1,11,32'hBB, 1,10,0, 10,0, 32'hAA,0, 0,0);
        step("iss_x11",     0, 0,0,0, 1,11,0, 10,11, 32'hAA,SB, 32'hBB,0);
        step("both_busy",   0, 0,0,0, 0,0,0, 10,11, 32'hAA,SB, 32'hBB,SB);
        step("async_rst",   1, 0,0,0, 0,0,0, 10,11, 0,0, 0,0);
        step("post_rst_a",  0, 0,0,0, 0,0,0, 5,7, 0,0, 0,0);
        step("post_rst_b",  0, 0,0,0, 0,0,0, 9,31, 0,0, 0,0);

        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: %0d expectations left, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_bypass_sb.md
# regfile_bypass_sb

Parametrised multi-read-port integer register file with write-through bypass and an optional per-register scoreboard. It replaces the fixed 2-read, 32×32 register file in the RISC-V core's decode stage. Same-cycle writeback data is forwarded to every read port. The scoreboard tracks registers with an outstanding producer so decode can stall on RAW hazards.

## Interface
Parameters:
- XLEN, 32, register width in bits
- NREG, 32, number of architectural registers; power of two, ≥ 2
- NRD, 2, number of read ports, 1..4
- AW, $clog2(NREG), address width (localparam; not overridable)

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous active-high reset
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW]
- rd_data  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN]
- rd_busy  out  NRD  port i's register has an outstanding producer
- wr_en  in  1  writeback enable
- wr_addr  in  AW  writeback address
- wr_data  in  XLEN  writeback data
- iss_en  in  1  issue of an instruction that will write iss_addr
- iss_addr  in  AW  destination of the issuing instruction
- flush  in  1  clear all busy bits (pipeline flush)

## Operation
- Storage: NREG × XLEN flops. Register 0 reads as 0 and is never written.
- Write: on the clk edge with wr_en=1 and wr_addr≠0, reg[wr_addr] ← wr_data.
- Read, port i, combinational: a = rd_addr[i].
  - a=0 → 0.
  - Else if wr_en and wr_addr=a → wr_data (bypass).
  - Else → reg[a].
  - All ports are independent; any number may name the same register.
- Scoreboard: one busy bit per register; bit 0 is constant 0.
- Busy update, priority on each clk edge:
  1. flush=1 → all bits cleared. Overrides any issue or writeback in the same cycle.
  2. Else iss_en=1 and iss_addr≠0 → busy[iss_addr] ← 1.
  3. Writeback with wr_en=1, wr_addr≠0, and wr_addr≠iss_addr (or iss_en=0) → busy[wr_addr] ← 0.
  4. Same-address issue and writeback in one cycle: the issue wins and the bit stays 1, because the new producer supersedes the retiring one.
- rd_busy[i], combinational:
  - Equals busy[rd_addr[i]].
  - Forced 0 when wr_en and wr_addr=rd_addr[i], since the data is bypassed this cycle.
  - Issue in the current cycle does not affect rd_busy until the next cycle.
- Writeback to a non-busy register is legal; it writes data and leaves busy unchanged.

## Timing
- Read latency: 0 cycles (combinational from rd_addr, wr_*).
- Write-to-array: 1 cycle. A read in the cycle after the write sees the value from the array.
- Busy set: visible 1 cycle after iss_en. Busy clear: visible in the same cycle as wr_en (bypass), and in the array the next cycle.
- Reset, asserted asynchronously:
  - All registers become 0 and all busy bits become 0.
  - rd_data shows 0 for every address (unless wr_en bypass is active, which is data-path only).
  - rd_busy=0.
- Reset released mid-operation: the first edge after deassertion performs normal updates. No warm-up cycles.
- rd_addr values ≥ NREG cannot occur because AW is exactly $clog2(NREG).

## Configuration
- REGFILE_SCOREBOARD_EN defined: scoreboard instantiated; behaviour as above.
- Not defined:
  - No busy flops are generated; rd_busy is tied to 0.
  - iss_en, iss_addr and flush are ignored (ports remain, so the interface is unchanged).
  - The data path and bypass are identical in both builds.

## Structure
- Package rf_pkg holds:
  - XLEN_DEF=32, NREG_DEF=32, NRD_MAX=4
  - the function that extracts port slices from flat vectors
- Sub-module rf_scoreboard: holds the busy bits, the set/clear/flush priority, and the rd_busy lookup with the writeback override. It is instantiated only under REGFILE_SCOREBOARD_EN.
- The top level holds the register array, the write logic, and the per-port read and bypass muxes, generated over NRD.

## Test plan
- Reset then read: assert rst; read x0..x31 on all ports → rd_data=0 and rd_busy=0.
- Write/readback: write x5=0xDEADBEEF; next cycle read x5 on ports 0 and 1 → 0xDEADBEEF on both. Write x0=0x1234 → x0 still reads 0.
- Bypass: wr_en, wr_addr=7, wr_data=0xA5A5A5A5 while rd_addr[1]=7 → rd_data[1]=0xA5A5A5A5 in the same cycle, while port 0 (x3) is unaffected.
- Scoreboard set/clear: issue x9 → busy[9]=1 next cycle. Writeback x9 with data 0x55 → rd_busy=0 and rd_data=0x55 in that same cycle.
- Simultaneous events:
  - Issue x9 and writeback x9 in one cycle → x9 stays busy and its data is updated.
  - Issue x4 with flush=1 → x4 is not busy.
  - Issue x0 → never busy.
- Config and reset: build without REGFILE_SCOREBOARD_EN and issue x9 → rd_busy stays 0. Assert rst asynchronously between clock edges with several regs busy → busy and data clear immediately.
